ps2_event_queue: RTL and testbench

PS2_EVENT_QUEUE -- requirements
Module: ps2_event_queue

---
 rtl/ps2_event_queue_if.sv | 34 +++
 rtl/ps2_event_queue.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_event_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_event_queue_if.sv
// Bundle of the byte-input, acknowledge and presentation signals that pass
// between the PS/2 keyboard front end and the CPU-facing event queue.
//   received_data/_en : incoming PS/2 byte and its one-cycle strobe
//   kb_ack            : CPU acknowledge toggle (asynchronous to clock50)
//   kb_clr            : one-cycle pulse clearing the sticky overflow flag
//   kb_ch/kb_flags    : presented scancode and its {brk, ext} flags
//   kb_tr             : event toggle, pending while it differs from kb_ack
//   kb_overflow       : sticky "an event was dropped"
//   kb_count          : number of entries waiting in the FIFO
interface ps2_event_queue_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          received_data;
  logic                received_data_en;
  logic                kb_ack;
  logic                kb_clr;
  logic [7:0]          kb_ch;
  logic [1:0]          kb_flags;
  logic                kb_tr;
  logic                kb_overflow;
  logic [DEPTH_LOG2:0] kb_count;

  // Producer/consumer side driving bytes and acknowledges.
  modport master (
    output received_data, received_data_en, kb_ack, kb_clr,
    input  kb_ch, kb_flags, kb_tr, kb_overflow, kb_count
  );

  // Event queue side.
  modport slave (
    input  received_data, received_data_en, kb_ack, kb_clr,
    output kb_ch, kb_flags, kb_tr, kb_overflow, kb_count
  );
endinterface

// File: rtl/ps2_event_queue.sv
// PS/2 scancode event queue.
// Decodes the raw PS/2 byte stream (E0 extended prefix, F0 break prefix,
// E1 pause sequence which is swallowed), stores {brk, ext, code} events in a
// FIFO and presents them one at a time on a toggle handshake.
// Ports:
//   clock50 : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   ps2     : slave modport of ps2_event_queue_if (bytes in, events out)
module ps2_event_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clock50,
  input  logic             reset_n,
  ps2_event_queue_if.slave ps2
);

  localparam int                  DATA_W   = 8;
  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DATA_W-1:0]   B_EXT    = 8'hE0;
  localparam logic [DATA_W-1:0]   B_BRK    = 8'hF0;
  localparam logic [DATA_W-1:0]   B_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PFX  = 2'd1,
    S_SKIP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_brk;
  logic                    r_ext;
  logic [2:0]              r_skip;
  logic                    r_ack_meta;
  logic                    r_ack_s;
  logic [DATA_W+1:0]       r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [DATA_W-1:0]       r_ch;
  logic [1:0]              r_flags;
  logic                    r_tr;
  logic                    r_ovf;

  logic [DATA_W-1:0]       w_byte;
  logic                    w_stb;
  logic                    w_emit;
  logic                    w_set_ext;
  logic                    w_set_brk;
  logic                    w_load_skip;
  logic                    w_dec_skip;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_drop;
  logic [DATA_W+1:0]       w_wr_data;
  logic [DATA_W+1:0]       w_head;

  assign w_byte = ps2.received_data;
  assign w_stb  = ps2.received_data_en;

  // ---- acknowledge synchronizer ----
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= ps2.kb_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // ---- decoder FSM: state register ----
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- decoder FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_stb) begin
          if (w_byte == B_EXT || w_byte == B_BRK) w_state_nxt = S_PFX;
          else if (w_byte == B_PAUSE)             w_state_nxt = S_SKIP;
        end
      end
      S_PFX: begin
        if (w_stb && w_byte != B_EXT && w_byte != B_BRK) w_state_nxt = S_IDLE;
      end
      S_SKIP: begin
        // <= 1 rather than == 1 so a corrupted zero count cannot lock us here.
        if (w_stb && r_skip <= 3'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- decoder FSM: outputs ----
  always_comb begin
    w_emit      = 1'b0;
    w_set_ext   = 1'b0;
    w_set_brk   = 1'b0;
    w_load_skip = 1'b0;
    w_dec_skip  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_stb) begin
          if (w_byte == B_EXT)        w_set_ext   = 1'b1;
          else if (w_byte == B_BRK)   w_set_brk   = 1'b1;
          else if (w_byte == B_PAUSE) w_load_skip = 1'b1;
          else                        w_emit      = 1'b1;
        end
      end
      S_PFX: begin
        if (w_stb) begin
          if (w_byte == B_EXT)      w_set_ext = 1'b1;
          else if (w_byte == B_BRK) w_set_brk = 1'b1;
          else                      w_emit    = 1'b1;
        end
      end
      S_SKIP: begin
        if (w_stb) w_dec_skip = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- prefix flags and pause-skip counter ----
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_brk  <= 1'b0;
      r_ext  <= 1'b0;
      r_skip <= 3'd0;
    end else begin
      if (w_emit) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else begin
        if (w_set_brk) r_brk <= 1'b1;
        if (w_set_ext) r_ext <= 1'b1;
      end
      if (w_load_skip)     r_skip <= 3'd7;
      else if (w_dec_skip) r_skip <= r_skip - 3'd1;
    end
  end

  // ---- FIFO control ----
  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  assign w_pop     = (r_tr == r_ack_s) && (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_wr      = w_emit && (!w_full || w_pop);
  assign w_drop    = w_emit && w_full && !w_pop;
  assign w_wr_data = {r_brk, r_ext, w_byte};
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clock50) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // ---- overflow flag: a same-cycle drop wins over clear ----
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n)        r_ovf <= 1'b0;
    else if (w_drop)     r_ovf <= 1'b1;
    else if (ps2.kb_clr) r_ovf <= 1'b0;
  end

  // ---- presentation register ----
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ch    <= '0;
      r_flags <= 2'b00;
      r_tr    <= 1'b0;
    end else if (w_pop) begin
      r_ch    <= w_head[DATA_W-1:0];
      r_flags <= w_head[DATA_W+1:DATA_W];
      r_tr    <= ~r_tr;
    end
  end

  assign ps2.kb_ch       = r_ch;
  assign ps2.kb_flags    = r_flags;
  assign ps2.kb_tr       = r_tr;
  assign ps2.kb_overflow = r_ovf;
  assign ps2.kb_count    = r_count;

endmodule

// File: tb/tb_ps2_event_queue.sv
module tb_ps2_event_queue;

  localparam int CAPACITY = 17;

  logic clk;
  logic rst_n;
  logic mon_en;
  logic force_ack0;
  int   n_checks;
  int   n_errors;

  logic [9:0] exp_q[$];
  logic       m_brk;
  logic       m_ext;
  int         m_skip;
  logic       m_ovf;

  ps2_event_queue_if #(.DEPTH_LOG2(4)) bus ();

  ps2_event_queue #(.DEPTH_LOG2(4)) dut (
    .clock50 (clk),
    .reset_n (rst_n),
    .ps2     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: prefixes accumulate, E1 outside a prefix swallows the
  // next seven bytes, anything else becomes an event; at most CAPACITY events
  // can be outstanding, extras are lost and raise the overflow flag.
  task automatic model_byte(input logic [7:0] b, input logic clr);
    logic drop;
    drop = 1'b0;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1 && !m_brk && !m_ext) m_skip = 7;
    else begin
      if (exp_q.size() < CAPACITY) exp_q.push_back({m_brk, m_ext, b});
      else drop = 1'b1;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    m_skip = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b, input logic clr);
    @(posedge clk);
    #1;
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    bus.kb_clr           = clr;
    model_byte(b, clr);
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
    bus.kb_clr           = 1'b0;
    bus.received_data    = 8'($urandom_range(0, 255));
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1;
    bus.kb_clr = 1'b1;
    m_ovf      = 1'b0;
    @(posedge clk);
    #1;
    bus.kb_clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Monitor: sole owner of kb_ack; consumes each pending event, compares it
  // with the scoreboard head and acknowledges it.
  initial begin
    logic [9:0] e;
    bus.kb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (force_ack0) bus.kb_ack = 1'b0;
      else if (mon_en && (bus.kb_tr != bus.kb_ack)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got %0h expected none at %0t",
                   {bus.kb_flags, bus.kb_ch}, $time);
        end else begin
          e = exp_q.pop_front();
          check("event", {22'd0, bus.kb_flags, bus.kb_ch}, {22'd0, e});
        end
        bus.kb_ack = ~bus.kb_ack;
      end
    end
  end

  initial begin
    logic [7:0] b;
    n_checks             = 0;
    n_errors             = 0;
    mon_en               = 1'b0;
    force_ack0           = 1'b1;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    bus.kb_clr           = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ch", bus.kb_ch, 8'h00);
    check("rst_flags", bus.kb_flags, 2'b00);
    check("rst_tr", bus.kb_tr, 1'b0);
    check("rst_count", bus.kb_count, 5'd0);
    check("rst_ovf", bus.kb_overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    force_ack0 = 1'b0;
    mon_en     = 1'b1;

    // single make, exact latency
    strobe(8'h1C, 1'b0);
    check("lat1_count", bus.kb_count, 5'd1);
    check("lat1_tr", bus.kb_tr, 1'b0);
    @(posedge clk);
    #1;
    check("lat2_tr", bus.kb_tr, 1'b1);
    check("lat2_ch", bus.kb_ch, 8'h1C);
    check("lat2_flags", bus.kb_flags, 2'b00);
    check("lat2_count", bus.kb_count, 5'd0);
    wait_drain(200);

    // extended break then plain make
    strobe(8'hE0, 1'b0);
    strobe(8'hF0, 1'b0);
    strobe(8'h75, 1'b0);
    strobe(8'h75, 1'b0);
    wait_drain(200);

    // pause sequence is swallowed
    strobe(8'hE1, 1'b0); strobe(8'h14, 1'b0); strobe(8'h77, 1'b0);
    strobe(8'hE1, 1'b0); strobe(8'hF0, 1'b0); strobe(8'h14, 1'b0);
    strobe(8'hF0, 1'b0); strobe(8'h77, 1'b0); strobe(8'h1C, 1'b0);
    wait_drain(200);

    // backpressure: ack held, 18 codes
    mon_en = 1'b0;
    for (int i = 1; i <= 18; i++) strobe(8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_ch", bus.kb_ch, 8'h01);
    check("bp_pending", bus.kb_tr ^ bus.kb_ack, 1'b1);
    check("bp_count", bus.kb_count, 5'd16);
    check("bp_ovf", bus.kb_overflow, m_ovf);

    // clear, then clear racing a drop into a full FIFO
    clr_pulse();
    check("clr_ovf", bus.kb_overflow, m_ovf);
    strobe(8'h13, 1'b1);
    check("race_ovf", bus.kb_overflow, m_ovf);
    check("race_count", bus.kb_count, 5'd16);
    clr_pulse();
    check("clr2_ovf", bus.kb_overflow, m_ovf);
    mon_en = 1'b1;
    wait_drain(1000);

    // reset mid-run with a queue, a pending event and a half prefix
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) strobe(8'h21 + 8'(i), 1'b0);
    strobe(8'hE0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_count", bus.kb_count, 5'd5);
    force_ack0 = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_ch", bus.kb_ch, 8'h00);
    check("mid_rst_flags", bus.kb_flags, 2'b00);
    check("mid_rst_tr", bus.kb_tr, 1'b0);
    check("mid_rst_count", bus.kb_count, 5'd0);
    check("mid_rst_ovf", bus.kb_overflow, 1'b0);
    @(negedge clk);
    rst_n                = 1'b1;
    bus.received_data    = 8'h29;
    bus.received_data_en = 1'b1;
    model_byte(8'h29, 1'b0);
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ch", bus.kb_ch, 8'h29);
    check("post_rst_flags", bus.kb_flags, 2'b00);
    check("post_rst_tr", bus.kb_tr, 1'b1);
    force_ack0 = 1'b0;
    mon_en     = 1'b1;
    wait_drain(200);

    // randomized byte stream with idle gaps
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      strobe(b, 1'b0);
      repeat ($urandom_range(5, 9)) @(posedge clk);
    end
    wait_drain(500);
    check("rand_ovf", bus.kb_overflow, 1'b0);
    check("rand_count", bus.kb_count, 5'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
